// File: rtl/mp_ff_array_pkg.sv
// Shared types and helpers for the multi-port flip-flop array: sweep FSM states,
// write-mask sizing and the per-byte merge used by both commit and read forwarding.
package mp_ff_array_pkg;

  typedef enum logic {
    SWEEP = 1'b0,
    IDLE  = 1'b1
  } sweep_state_e;

  // Widest entry the byte-merge helper handles; modules pad narrower entries up to it.
  localparam int MERGE_MAX_W = 256;
  localparam int MERGE_MAX_B = MERGE_MAX_W / 8;

  function automatic int calc_mask_w(input int width);
    return (width + 7) / 8;
  endfunction

  function automatic logic [MERGE_MAX_W-1:0] byte_merge(
    input logic [MERGE_MAX_W-1:0] old_val,
    input logic [MERGE_MAX_W-1:0] new_val,
    input logic [MERGE_MAX_B-1:0] mask
  );
    logic [MERGE_MAX_W-1:0] res;
    res = old_val;
    for (int b = 0; b < MERGE_MAX_B; b++) begin
      if (mask[b]) res[b*8 +: 8] = new_val[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/mp_ff_array_sweep.sv
// Clear-sweep controller: walks every entry once after reset or an accepted
// flash-clear, then reports ready until the next clear.
module mp_ff_array_sweep
  import mp_ff_array_pkg::*;
#(
  parameter int S_INDEX = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  output logic               sweep_we,
  output logic [S_INDEX-1:0] sweep_addr,
  output logic               ready
);

  localparam logic [S_INDEX-1:0] LAST_PTR = '1;

  sweep_state_e       state_q, state_n;
  logic [S_INDEX-1:0] ptr_q, ptr_n;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= SWEEP;
      ptr_q   <= '0;
    end else begin
      state_q <= state_n;
      ptr_q   <= ptr_n;
    end
  end

  // A clear request is only honoured from IDLE, so a sweep never restarts itself.
  always_comb begin
    state_n  = state_q;
    ptr_n    = ptr_q;
    sweep_we = 1'b0;
    ready    = 1'b0;
    case (state_q)
      SWEEP: begin
        sweep_we = 1'b1;
        if (ptr_q == LAST_PTR) begin
          state_n = IDLE;
          ptr_n   = '0;
        end else begin
          ptr_n = ptr_q + 1'b1;
        end
      end
      IDLE: begin
        ready = 1'b1;
        if (clr) begin
          state_n = SWEEP;
          ptr_n   = '0;
        end
      end
    endcase
  end

  assign sweep_addr = ptr_q;

endmodule

// File: rtl/mp_ff_array.sv
// Multi-port flip-flop array with byte-masked writes and port-priority collision merge.
// Define MP_FF_ARRAY_BYPASS_EN to forward pending writes to reads in the same cycle.
module mp_ff_array
  import mp_ff_array_pkg::*;
#(
  parameter int S_INDEX = 4,
  parameter int WIDTH   = 8,
  parameter int NUM_RP  = 2,
  parameter int NUM_WP  = 2,
  parameter int MASK_W  = calc_mask_w(WIDTH)
) (
  input  logic                       clk0,
  input  logic                       rst0_n,
  input  logic [NUM_RP-1:0]          rcsb,
  input  logic [NUM_RP*S_INDEX-1:0]  raddr,
  output logic [NUM_RP*WIDTH-1:0]    rdata,
  input  logic [NUM_WP-1:0]          wcsb,
  input  logic [NUM_WP*S_INDEX-1:0]  waddr,
  input  logic [NUM_WP*WIDTH-1:0]    wdata,
  input  logic [NUM_WP*MASK_W-1:0]   wmask,
  input  logic                       clr,
  output logic                       ready
);

  localparam int NUM_SETS = 2 ** S_INDEX;

  logic               sweep_we;
  logic [S_INDEX-1:0] sweep_addr;
  logic               access_en;

  logic [S_INDEX-1:0] raddr_q [NUM_RP];
  logic [NUM_WP-1:0]  wvalid_q;
  logic [S_INDEX-1:0] waddr_q [NUM_WP];
  logic [WIDTH-1:0]   wdata_q [NUM_WP];
  logic [MASK_W-1:0]  wmask_q [NUM_WP];

  logic [WIDTH-1:0]   mem      [NUM_SETS];
  logic [WIDTH-1:0]   mem_next [NUM_SETS];

  function automatic logic [WIDTH-1:0] merge_entry(
    input logic [WIDTH-1:0]  old_val,
    input logic [WIDTH-1:0]  new_val,
    input logic [MASK_W-1:0] mask
  );
    logic [MERGE_MAX_W-1:0] old_w, new_w, res_w;
    logic [MERGE_MAX_B-1:0] mask_w;
    old_w  = '0;
    new_w  = '0;
    mask_w = '0;
    old_w[WIDTH-1:0]   = old_val;
    new_w[WIDTH-1:0]   = new_val;
    mask_w[MASK_W-1:0] = mask;
    res_w = byte_merge(old_w, new_w, mask_w);
    return res_w[WIDTH-1:0];
  endfunction

  mp_ff_array_sweep #(
    .S_INDEX (S_INDEX)
  ) u_sweep (
    .clk        (clk0),
    .rst_n      (rst0_n),
    .clr        (clr),
    .sweep_we   (sweep_we),
    .sweep_addr (sweep_addr),
    .ready      (ready)
  );

  // Accesses arriving with an accepted clear are dropped along with everything during a sweep.
  assign access_en = ready & ~clr;

  always_ff @(posedge clk0) begin
    if (!rst0_n) begin
      for (int i = 0; i < NUM_RP; i++) raddr_q[i] <= '0;
      for (int j = 0; j < NUM_WP; j++) waddr_q[j] <= '0;
      wvalid_q <= '0;
    end else begin
      for (int i = 0; i < NUM_RP; i++) begin
        if (access_en && !rcsb[i]) raddr_q[i] <= raddr[i*S_INDEX +: S_INDEX];
      end
      for (int j = 0; j < NUM_WP; j++) begin
        wvalid_q[j] <= access_en && !wcsb[j];
        if (access_en && !wcsb[j]) waddr_q[j] <= waddr[j*S_INDEX +: S_INDEX];
      end
    end
  end

  always_ff @(posedge clk0) begin
    for (int j = 0; j < NUM_WP; j++) begin
      if (access_en && !wcsb[j]) begin
        wdata_q[j] <= wdata[j*WIDTH +: WIDTH];
        wmask_q[j] <= wmask[j*MASK_W +: MASK_W];
      end
    end
  end

  // Ports are folded in ascending order so the highest-index port owns each contested byte.
  always_comb begin
    for (int e = 0; e < NUM_SETS; e++) begin
      mem_next[e] = mem[e];
      for (int j = 0; j < NUM_WP; j++) begin
        if (wvalid_q[j] && waddr_q[j] == S_INDEX'(e)) begin
          mem_next[e] = merge_entry(mem_next[e], wdata_q[j], wmask_q[j]);
        end
      end
      if (sweep_we && sweep_addr == S_INDEX'(e)) mem_next[e] = '0;
    end
  end

  always_ff @(posedge clk0) begin
    for (int e = 0; e < NUM_SETS; e++) mem[e] <= mem_next[e];
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < NUM_RP; i++) begin
      if (ready) begin
`ifdef MP_FF_ARRAY_BYPASS_EN
        rdata[i*WIDTH +: WIDTH] = mem_next[raddr_q[i]];
`else
        rdata[i*WIDTH +: WIDTH] = mem[raddr_q[i]];
`endif
      end
    end
  end

endmodule

// File: tb/tb_mp_ff_array.sv
// Bench for mp_ff_array (WIDTH=16, 2 read / 3 write ports): directed vector table
// followed by random traffic checked against a queue-based behavioural model.
module tb_mp_ff_array;

  localparam int S_INDEX  = 4;
  localparam int WIDTH    = 16;
  localparam int NUM_RP   = 2;
  localparam int NUM_WP   = 3;
  localparam int MASK_W   = 2;
  localparam int NUM_SETS = 16;
`ifdef MP_FF_ARRAY_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk0 = 1'b0;
  logic        rst0_n;
  logic [1:0]  rcsb;
  logic [7:0]  raddr;
  logic [31:0] rdata;
  logic [2:0]  wcsb;
  logic [11:0] waddr;
  logic [47:0] wdata;
  logic [5:0]  wmask;
  logic        clr;
  logic        ready;

  int num_compared   = 0;
  int num_mismatched = 0;

  mp_ff_array #(
    .S_INDEX (S_INDEX),
    .WIDTH   (WIDTH),
    .NUM_RP  (NUM_RP),
    .NUM_WP  (NUM_WP),
    .MASK_W  (MASK_W)
  ) u_dut (
    .clk0   (clk0),
    .rst0_n (rst0_n),
    .rcsb   (rcsb),
    .raddr  (raddr),
    .rdata  (rdata),
    .wcsb   (wcsb),
    .waddr  (waddr),
    .wdata  (wdata),
    .wmask  (wmask),
    .clr    (clr),
    .ready  (ready)
  );

  always #5 clk0 = ~clk0;

  typedef struct {
    logic        rst_n;
    logic        clr;
    logic [1:0]  rcsb;
    logic [7:0]  raddr;
    logic [2:0]  wcsb;
    logic [11:0] waddr;
    logic [47:0] wdata;
    logic [5:0]  wmask;
    logic        exp_ready;
    logic [1:0]  chk_rd;
    logic [31:0] exp_rd;
  } vec_t;

  typedef struct packed {
    logic [3:0]  addr;
    logic [15:0] data;
    logic [1:0]  mask;
  } wr_t;

  vec_t vecs [$];

  // Reference model: array contents, latched read addresses, writes awaiting commit,
  // and the number of clock edges left before the array is usable again.
  logic [15:0] model_mem   [NUM_SETS];
  logic [3:0]  model_raddr [NUM_RP];
  wr_t         pending [$];
  int          sweep_left = NUM_SETS;

  function automatic logic [15:0] apply_bytes(input logic [15:0] old_v, input logic [15:0] new_v,
                                              input logic [1:0] m);
    logic [15:0] r;
    r = old_v;
    if (m[0]) r[7:0]  = new_v[7:0];
    if (m[1]) r[15:8] = new_v[15:8];
    return r;
  endfunction

  task automatic model_step();
    wr_t w;
    if (!rst0_n) begin
      sweep_left = NUM_SETS;
      pending.delete();
      foreach (model_raddr[i]) model_raddr[i] = '0;
      foreach (model_mem[e]) model_mem[e] = '0;
    end else if (sweep_left == 0) begin
      foreach (pending[k]) model_mem[pending[k].addr] =
          apply_bytes(model_mem[pending[k].addr], pending[k].data, pending[k].mask);
      pending.delete();
      if (clr) begin
        sweep_left = NUM_SETS;
        foreach (model_mem[e]) model_mem[e] = '0;
      end else begin
        for (int j = 0; j < NUM_WP; j++) begin
          if (!wcsb[j]) begin
            w.addr = waddr[j*4 +: 4];
            w.data = wdata[j*16 +: 16];
            w.mask = wmask[j*2 +: 2];
            pending.push_back(w);
          end
        end
        for (int i = 0; i < NUM_RP; i++) begin
          if (!rcsb[i]) model_raddr[i] = raddr[i*4 +: 4];
        end
      end
    end else begin
      sweep_left--;
    end
  endtask

  function automatic logic [15:0] model_read(input int p);
    logic [15:0] v;
    if (sweep_left != 0) return 16'h0000;
    v = model_mem[model_raddr[p]];
    if (BYP) begin
      foreach (pending[k]) begin
        if (pending[k].addr == model_raddr[p]) v = apply_bytes(v, pending[k].data, pending[k].mask);
      end
    end
    return v;
  endfunction

  function automatic vec_t idle_vec(input logic er, input logic [1:0] chk,
                                    input logic [15:0] e0, input logic [15:0] e1);
    vec_t v;
    v.rst_n = 1'b1;  v.clr = 1'b0;
    v.rcsb = 2'b11;  v.raddr = '0;
    v.wcsb = 3'b111; v.waddr = '0; v.wdata = '0; v.wmask = '0;
    v.exp_ready = er; v.chk_rd = chk; v.exp_rd = {e1, e0};
    return v;
  endfunction

  function automatic vec_t add_read(input vec_t v, input int p, input logic [3:0] a);
    vec_t r;
    r = v;
    r.rcsb[p] = 1'b0;
    r.raddr[p*4 +: 4] = a;
    return r;
  endfunction

  function automatic vec_t add_write(input vec_t v, input int p, input logic [3:0] a,
                                     input logic [15:0] d, input logic [1:0] m);
    vec_t r;
    r = v;
    r.wcsb[p] = 1'b0;
    r.waddr[p*4 +: 4]  = a;
    r.wdata[p*16 +: 16] = d;
    r.wmask[p*2 +: 2]  = m;
    return r;
  endfunction

  function automatic void push_idle(input int n, input logic er, input logic [15:0] e0,
                                    input logic [15:0] e1);
    for (int k = 0; k < n; k++) vecs.push_back(idle_vec(er, 2'b11, e0, e1));
  endfunction

  function automatic void push_read_all();
    for (int k = 0; k < NUM_SETS; k++)
      vecs.push_back(add_read(add_read(idle_vec(1'b1, 2'b11, 16'h0, 16'h0), 0, 4'(k)), 1, 4'(15 - k)));
  endfunction

  task automatic applyStimulus(input vec_t v);
    rst0_n = v.rst_n;
    clr    = v.clr;
    rcsb   = v.rcsb;
    raddr  = v.raddr;
    wcsb   = v.wcsb;
    waddr  = v.waddr;
    wdata  = v.wdata;
    wmask  = v.wmask;
  endtask

  task automatic run_edge();
    @(posedge clk0);
    model_step();
    @(negedge clk0);
  endtask

  task automatic checkOutput(input string nm, input int idx, input logic [15:0] act,
                             input logic [15:0] exp);
    num_compared++;
    if (act !== exp) begin
      num_mismatched++;
      $display("[TB] FAIL %s #%0d: got %h, expected %h", nm, idx, act, exp);
    end
  endtask

  initial begin
    vec_t v, rst_v, clr_v;

    rst_v = idle_vec(1'b0, 2'b11, 16'h0, 16'h0);
    rst_v.rst_n = 1'b0;
    clr_v = idle_vec(1'b0, 2'b11, 16'h0, 16'h0);
    clr_v.clr = 1'b1;

    // Reset, 16-cycle sweep, then every entry reads zero.
    vecs.push_back(rst_v);
    vecs.push_back(rst_v);
    push_idle(15, 1'b0, 16'h0, 16'h0);
    push_idle(1, 1'b1, 16'h0, 16'h0);
    push_read_all();

    // Single-port write with a concurrent read of the same entry.
    v = add_write(add_read(idle_vec(1'b1, 2'b11, BYP ? 16'h00A5 : 16'h0000, 16'h0), 0, 4'd3),
                  0, 4'd3, 16'h00A5, 2'b01);
    vecs.push_back(v);
    push_idle(1, 1'b1, 16'h00A5, 16'h0);

    // Two-port collision, per-byte priority.
    v = add_read(idle_vec(1'b1, 2'b11, 16'h00A5, BYP ? 16'h2211 : 16'h0000), 1, 4'd5);
    v = add_write(v, 0, 4'd5, 16'h1111, 2'b11);
    v = add_write(v, 1, 4'd5, 16'h2222, 2'b10);
    vecs.push_back(v);
    push_idle(1, 1'b1, 16'h00A5, 16'h2211);

    // Three-port collision where the top port is a no-op mask.
    v = add_read(idle_vec(1'b1, 2'b11, BYP ? 16'h1278 : 16'h0000, 16'h2211), 0, 4'd6);
    v = add_write(v, 0, 4'd6, 16'h1234, 2'b11);
    v = add_write(v, 1, 4'd6, 16'h5678, 2'b01);
    v = add_write(v, 2, 4'd6, 16'h9ABC, 2'b00);
    vecs.push_back(v);
    push_idle(1, 1'b1, 16'h1278, 16'h2211);

    // Three-port collision, each byte owned by a different winner.
    v = add_read(idle_vec(1'b1, 2'b11, 16'h1278, BYP ? 16'h2233 : 16'h0000), 1, 4'd7);
    v = add_write(v, 0, 4'd7, 16'h1111, 2'b11);
    v = add_write(v, 1, 4'd7, 16'h2222, 2'b10);
    v = add_write(v, 2, 4'd7, 16'h3333, 2'b01);
    vecs.push_back(v);
    push_idle(1, 1'b1, 16'h1278, 16'h2233);

    // Fill with ones, then clear with a same-cycle write that must be dropped.
    for (int k = 0; k < 8; k++) begin
      v = add_write(idle_vec(1'b1, 2'b00, 16'h0, 16'h0), 0, 4'(2 * k), 16'hFFFF, 2'b11);
      vecs.push_back(add_write(v, 1, 4'(2 * k + 1), 16'hFFFF, 2'b11));
    end
    vecs.push_back(add_read(add_read(idle_vec(1'b1, 2'b11, 16'hFFFF, 16'hFFFF), 0, 4'd2), 1, 4'd13));
    vecs.push_back(add_read(add_write(clr_v, 0, 4'd2, 16'h3C3C, 2'b11), 0, 4'd4));
    push_idle(15, 1'b0, 16'h0, 16'h0);
    push_idle(1, 1'b1, 16'h0, 16'h0);
    push_read_all();

    // Clear requested again mid-sweep: completion time is unchanged.
    vecs.push_back(clr_v);
    push_idle(7, 1'b0, 16'h0, 16'h0);
    vecs.push_back(clr_v);
    push_idle(7, 1'b0, 16'h0, 16'h0);
    push_idle(1, 1'b1, 16'h0, 16'h0);

    // Reset mid-sweep restarts the full sweep.
    vecs.push_back(clr_v);
    push_idle(4, 1'b0, 16'h0, 16'h0);
    vecs.push_back(rst_v);
    push_idle(15, 1'b0, 16'h0, 16'h0);
    push_idle(1, 1'b1, 16'h0, 16'h0);

    // Held read address follows later writes by other ports.
    vecs.push_back(add_read(idle_vec(1'b1, 2'b11, 16'h0, 16'h0), 0, 4'd9));
    vecs.push_back(add_write(idle_vec(1'b1, 2'b11, BYP ? 16'h0042 : 16'h0000, 16'h0),
                             1, 4'd9, 16'h0042, 2'b01));
    push_idle(1, 1'b1, 16'h0042, 16'h0);
    vecs.push_back(add_write(idle_vec(1'b1, 2'b11, 16'h0042, 16'h0), 2, 4'd9, 16'hFFFF, 2'b00));
    push_idle(1, 1'b1, 16'h0042, 16'h0);
    vecs.push_back(add_write(idle_vec(1'b1, 2'b11, BYP ? 16'hAB42 : 16'h0042, 16'h0),
                             0, 4'd9, 16'hAB00, 2'b10));
    push_idle(1, 1'b1, 16'hAB42, 16'h0);

    $display("[TB] directed phase: %0d vectors", vecs.size());
    foreach (vecs[n]) begin
      applyStimulus(vecs[n]);
      run_edge();
      checkOutput("dir_ready", n, {15'b0, ready}, {15'b0, vecs[n].exp_ready});
      if (vecs[n].chk_rd[0]) checkOutput("dir_rdata0", n, rdata[15:0], vecs[n].exp_rd[15:0]);
      if (vecs[n].chk_rd[1]) checkOutput("dir_rdata1", n, rdata[31:16], vecs[n].exp_rd[31:16]);
    end

    $display("[TB] random phase");
    for (int c = 0; c < 600; c++) begin
      v = idle_vec(1'b0, 2'b00, 16'h0, 16'h0);
      v.rst_n = ($urandom_range(0, 299) != 0);
      v.clr   = ($urandom_range(0, 39) == 0);
      v.rcsb  = 2'($urandom);
      v.wcsb  = 3'($urandom);
      v.wmask = 6'($urandom);
      v.wdata = {16'($urandom), 16'($urandom), 16'($urandom)};
      for (int p = 0; p < NUM_RP; p++)
        v.raddr[p*4 +: 4] = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 3)) : 4'($urandom);
      for (int p = 0; p < NUM_WP; p++)
        v.waddr[p*4 +: 4] = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 3)) : 4'($urandom);
      applyStimulus(v);
      run_edge();
      checkOutput("rnd_ready", c, {15'b0, ready}, {15'b0, sweep_left == 0});
      for (int p = 0; p < NUM_RP; p++)
        checkOutput(p == 0 ? "rnd_rdata0" : "rnd_rdata1", c, rdata[p*16 +: 16], model_read(p));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
    $finish;
  end

endmodule
